// File: rtl/control_fsm.sv
// control_fsm: multi-cycle fetch/decode/exec/mem/wb sequencer; define CTRL_TRAP_ILLEGAL_EN to trap opcodes 0x9-0xE
module control_fsm #(
  parameter int WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] ir,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  regA,
  output logic [2:0]  alu_op,
  output logic        alu_srcb,
  output logic        rf_we,
  output logic        wb_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        halted,
  output logic        bus_err,
  output logic        illegal,
  output logic [2:0]  state
);
  localparam int CW = $clog2(WAIT_MAX + 1);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;
`ifdef CTRL_TRAP_ILLEGAL_EN
  localparam state_t ILL_NEXT = HALT;
`else
  localparam state_t ILL_NEXT = FETCH;
`endif
  state_t st, nxt;
  logic [CW-1:0] cnt;
  logic [3:0] op;
  logic is_alu, is_ls, waiting, timeout, unused_ir;
  assign op = ir[15:12];
  assign is_alu = op >= 4'h1 && op <= 4'h4;
  assign is_ls = op == 4'h6 || op == 4'h7;
  assign waiting = (st == FETCH || st == MEM) && !mem_ready;
  assign timeout = waiting && cnt == CW'(WAIT_MAX - 1);
  assign state = st;
  assign unused_ir = ^ir[11:0];
  // next state: mem_ready beats the wait timeout, HALT only left through reset
  always_comb begin
    nxt = st;
    case (st)
      FETCH:   nxt = mem_ready ? DECODE : timeout ? HALT : FETCH;
      DECODE:  nxt = op == 4'h0 ? FETCH : op <= 4'h8 ? EXEC : op == 4'hF ? HALT : ILL_NEXT;
      EXEC:    nxt = is_ls ? MEM : op == 4'h8 ? FETCH : WB;
      MEM:     nxt = mem_ready ? (op == 4'h6 ? WB : FETCH) : timeout ? HALT : MEM;
      WB:      nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  // datapath strobes decoded from state and IR, forced idle while reset is held
  always_comb begin
    regA = 2'b10;
    alu_op = 3'b111;
    alu_srcb = 1'b0;
    rf_we = 1'b0;
    wb_sel = 1'b0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    ir_we = 1'b0;
    pc_inc = 1'b0;
    pc_load = 1'b0;
    if (rst_n) begin
      case (st)
        FETCH: begin
          mem_req = 1'b1;
          ir_we = mem_ready;
          pc_inc = mem_ready;
        end
        DECODE: regA = (op >= 4'h1 && op <= 4'h7) ? 2'b01 : op == 4'h8 ? 2'b00 : 2'b10;
        EXEC: begin
          alu_op = is_alu ? 3'(op - 4'h1) : op == 4'h8 ? 3'b111 : 3'b000;
          alu_srcb = !is_alu && op != 4'h8;
          regA = op == 4'h7 ? 2'b00 : 2'b10;
          pc_load = op == 4'h8 && zero;
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we = op == 4'h7;
          regA = op == 4'h7 ? 2'b00 : 2'b10;
        end
        WB: begin
          rf_we = 1'b1;
          wb_sel = op == 4'h6;
        end
        default: regA = 2'b10;
      endcase
    end
  end
  // state, memory wait counter (cleared on every state change) and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= FETCH;
      cnt <= '0;
      halted <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      st <= nxt;
      cnt <= nxt != st ? '0 : waiting ? cnt + 1'b1 : cnt;
      halted <= halted | (nxt == HALT);
      bus_err <= bus_err | timeout;
    end
  end
`ifdef CTRL_TRAP_ILLEGAL_EN
  // sticky illegal-opcode flag raised when DECODE sees 0x9-0xE
  always_ff @(posedge clk) begin
    if (!rst_n) illegal <= 1'b0;
    else if (st == DECODE && op >= 4'h9 && op <= 4'hE) illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif
endmodule
